// File: rtl/ysyx_24080006_clint_if.sv
// AXI4 bus bundle shared by the core-side master and the CLINT slave.
// Single-beat 32-bit transfers with ID, LEN, SIZE, LAST and STRB.
interface ysyx_24080006_axi;
    // Read address channel
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    // Read data channel
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Write address channel
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;

    // Write data channel
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    // Write response channel
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_24080006_clint.sv
// Core-local interruptor: 64-bit mtime counter, writable mtimecmp and the
// machine timer interrupt, exposed as a single-beat 32-bit AXI4 slave.
// Register map by addr[3:2]: 0/1 = mtime lo/hi (RO), 2/3 = mtimecmp lo/hi (RW).
module ysyx_24080006_clint #(
    parameter int PRESCALE = 1
) (
    input  logic            clock,
    input  logic            reset,
    ysyx_24080006_axi.slave axi,
    output logic            mtip
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         CNT_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDATA = 2'd1,
        WDATA = 2'd2,
        WRESP = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ar_ready;
    logic             aw_ready;
    logic             r_valid;
    logic             w_ready;
    logic             b_valid;
    logic             ar_hs;
    logic             aw_hs;
    logic             w_hs;

    logic [CNT_W-1:0] presc_cnt;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;

    logic [31:0]      rd_sel;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic [3:0]       rid;

    logic [1:0]       wr_ofs;
    logic             wr_len_zero;
    logic [3:0]       wr_id;
    logic             wr_ok;
    logic [31:0]      cmp_old;
    logic [31:0]      cmp_new;
    logic [1:0]       bresp;
    logic [3:0]       bid;

    // State register; a reset mid-transaction drops straight back to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and channel handshake outputs; a pending read beats a pending write.
    always_comb begin
        state_next = state;
        ar_ready   = 1'b0;
        aw_ready   = 1'b0;
        r_valid    = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        case (state)
            IDLE: begin
                ar_ready = reset;
                aw_ready = reset & ~axi.arvalid;
                if (reset && axi.arvalid) begin
                    state_next = RDATA;
                end else if (reset && axi.awvalid) begin
                    state_next = WDATA;
                end
            end
            RDATA: begin
                r_valid = 1'b1;
                if (axi.rready) begin
                    state_next = IDLE;
                end
            end
            WDATA: begin
                w_ready = 1'b1;
                if (axi.wvalid) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                b_valid = 1'b1;
                if (axi.bready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ar_hs = ar_ready & axi.arvalid;
    assign aw_hs = aw_ready & axi.awvalid;
    assign w_hs  = w_ready & axi.wvalid;

    assign axi.arready = ar_ready;
    assign axi.awready = aw_ready;
    assign axi.rvalid  = r_valid;
    assign axi.rlast   = r_valid;
    assign axi.wready  = w_ready;
    assign axi.bvalid  = b_valid;
    assign axi.rdata   = rdata;
    assign axi.rresp   = rresp;
    assign axi.rid     = rid;
    assign axi.bresp   = bresp;
    assign axi.bid     = bid;

    // Prescaler and free-running mtime; mtime steps on the last prescaler count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
            mtime     <= '0;
        end else if (presc_cnt == CNT_LAST) begin
            presc_cnt <= '0;
            mtime     <= mtime + 64'd1;
        end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
        end
    end

    // Interrupt pending is the registered unsigned compare of the current values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

    // Read mux over the four word-sized views of the two 64-bit registers.
    always_comb begin
        rd_sel = '0;
        case (axi.araddr[3:2])
            2'd0:    rd_sel = mtime[31:0];
            2'd1:    rd_sel = mtime[63:32];
            2'd2:    rd_sel = mtimecmp[31:0];
            default: rd_sel = mtimecmp[63:32];
        endcase
    end

    // Read payload is captured at the AR handshake and held until it is consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
            rid   <= '0;
        end else if (ar_hs) begin
            rdata <= rd_sel;
            rresp <= (axi.arlen == 8'd0) ? RESP_OKAY : RESP_SLVERR;
            rid   <= axi.arid;
        end
    end

    // Write address attributes are remembered until the data beat arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ofs      <= '0;
            wr_len_zero <= 1'b0;
            wr_id       <= '0;
        end else if (aw_hs) begin
            wr_ofs      <= axi.awaddr[3:2];
            wr_len_zero <= (axi.awlen == 8'd0);
            wr_id       <= axi.awid;
        end
    end

    // Byte-lane merge of the write data into the targeted mtimecmp half.
    always_comb begin
        wr_ok   = wr_ofs[1] & wr_len_zero;
        cmp_old = wr_ofs[0] ? mtimecmp[63:32] : mtimecmp[31:0];
        cmp_new = cmp_old;
        for (int i = 0; i < 4; i++) begin
            if (axi.wstrb[i]) begin
                cmp_new[8*i +: 8] = axi.wdata[8*i +: 8];
            end
        end
    end

    // mtimecmp only changes on an accepted single-beat write to offset 2 or 3.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtimecmp <= '1;
        end else if (w_hs && wr_ok) begin
            if (wr_ofs[0]) begin
                mtimecmp[63:32] <= cmp_new;
            end else begin
                mtimecmp[31:0] <= cmp_new;
            end
        end
    end

    // Write response is fixed at the W handshake so B carries the outcome of that beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bresp <= RESP_OKAY;
            bid   <= '0;
        end else if (w_hs) begin
            bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            bid   <= wr_id;
        end
    end
endmodule

// File: doc/ysyx_24080006_clint.md
# ysyx_24080006_clint

Core-local interruptor: AXI4 slave that sits directly downstream of the core's AXI master, behind the arbiter, on the memory-mapped bus. It holds the 64-bit `mtime` free-running counter and a 64-bit writable `mtimecmp` compare register. It drives the machine timer interrupt `mtip` back to the core. It serves single-beat 32-bit reads and writes with a small read/write FSM.

## Interface
- `PRESCALE`, default 1: clock cycles per `mtime` increment; legal range ≥1.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `axi`  slave modport  ysyx_24080006_axi  AXI4 slave, 32-bit data. Uses the AR/R/AW/W/B channels with ID, LEN, SIZE, LAST and STRB. Address bits [3:2] select the register; other address bits are ignored.
- `mtip`  out  1  registered machine timer interrupt pending.

## Operation
- Register map by `addr[3:2]`:
  - 0 = `mtime[31:0]` (RO)
  - 1 = `mtime[63:32]` (RO)
  - 2 = `mtimecmp[31:0]` (RW)
  - 3 = `mtimecmp[63:32]` (RW)
- Prescaler: a counter from 0 to PRESCALE-1. `mtime` increments by 1 on the cycle the counter equals PRESCALE-1, and the counter returns to 0. With PRESCALE=1, `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0. It is never software-writable.
- `mtip` is registered `mtime >= mtimecmp`, an unsigned 64-bit compare of the current register values. It updates every cycle.
- FSM states:
  - IDLE: `arready`=1 and `awready`=1.
  - RDATA: `rvalid`=1, waiting for `rready`.
  - WDATA: `wready`=1, waiting for `wvalid`.
  - WRESP: `bvalid`=1, waiting for `bready`.
- Transitions:
  - IDLE→RDATA on AR handshake.
  - IDLE→WDATA on AW handshake.
  - WDATA→WRESP on W handshake.
  - RDATA→IDLE on R handshake.
  - WRESP→IDLE on B handshake.
- If `arvalid` and `awvalid` are both high in IDLE, the read wins: `awready` is 0 that cycle.
- Read:
  - `rdata` is the selected register captured at the AR handshake cycle, so it does not include that cycle's increment.
  - `rid` = latched `arid`; `rlast` = 1.
  - `rresp` = OKAY if `arlen`==0, else SLVERR. Any LEN returns exactly one beat with `rlast`=1.
- Write:
  - `awaddr`, `awid` and `awlen` are latched at the AW handshake.
  - At the W handshake, the `mtimecmp` half is updated byte-wise per `wstrb`, only if the target is offset 2/3 and `awlen`==0.
  - `bid` = latched `awid`.
  - `bresp` = OKAY for offset 2/3 with LEN 0; otherwise SLVERR with no state change.
  - `wlast` is ignored.
- Reset values:
  - `mtime`=0, prescaler=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `mtip`=0, state=IDLE.
  - All valid/ready outputs 0, except `arready`/`awready`, which become 1 in the first cycle after reset release.
  - `rdata`/`rresp`/`rid`/`bid`/`bresp` are 0.
- Reset asserted mid-transaction aborts it immediately: outputs take reset values and no response is issued.

## Timing
- AR handshake in cycle N → `rvalid`=1 in N+1, held with stable payload until `rready`.
- AW handshake in N → `wready`=1 from N+1. W handshake in M → `mtimecmp` updated at the end of M, `bvalid`=1 in M+1.
- `mtip` reflects a new `mtimecmp` one cycle after the write's end-of-cycle update, i.e. `mtip` changes in cycle M+2.
- Back-to-back throughput: one read per 2 cycles when `rready` is held high.
- The 32-bit halves of `mtime` are not read atomically. Software handles a carry between the low-half and high-half reads.
- A two-write `mtimecmp` update may produce a transient `mtip` between the two writes. This is permitted.

## Test plan
- Reset release, PRESCALE=1, read offset 0 at the first idle cycle → `rdata` equals the cycle count since release (0 at the first possible handshake), `rresp`=OKAY, `rlast`=1, `rid` echoes `arid`=5.
- Write `mtimecmp` low=0x40, high=0 with `wstrb`=4'hF → `bresp`=OKAY; `mtip` rises exactly when `mtime` reaches 0x40 (plus 1-cycle register delay) and stays high.
- `wstrb`=4'b0010 write of 0xAABBCCDD to offset 3 from reset → `mtimecmp[63:32]` reads back 0xFFFFCCFF.
- Write to offset 0 → `bresp`=SLVERR and the `mtime` sequence is unaffected. `arlen`=3 read → one beat, SLVERR, `rlast`=1.
- Simultaneous `arvalid`/`awvalid` in IDLE → read completes first, then AW is accepted; `rready` held low 10 cycles keeps `rvalid`/`rdata` stable.
- PRESCALE=4: `mtime` advances once per 4 cycles. `mtime` preset near wrap via force to 2^64-2 → wraps to 0 and `mtip` drops if `mtimecmp` ≥ 2^64-1.
- Reset asserted during RDATA → `rvalid` drops asynchronously and the next transaction behaves as after a fresh reset.
